// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_pkg
// Description : Shared definitions for the video-in-pipeline blocks: burst
//               writer FSM state encoding and a bit-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

  // Burst writer FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Number of bits needed to hold the value itself (minimum 1)
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vip_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : vip_burst_writer
// Description : Drains a show-ahead FIFO into fixed-length memory write
//               bursts. Requests the port once a full burst is buffered,
//               streams one burst per grant, walks the frame address and
//               pulses frame_done when the frame wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_burst_writer
  import vip_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 16,
  parameter int C_CNT_WIDTH   = 5,
  parameter int C_BURST_LEN   = 8,
  parameter int C_ADDR_WIDTH  = 21,
  parameter int C_BASE_ADDR   = 0,
  parameter int C_FRAME_WORDS = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [C_DATA_WIDTH-1:0] fifo_dout,
  input  logic                    fifo_empty,
  input  logic [C_CNT_WIDTH-1:0]  fifo_count,
  output logic                    fifo_rd_en,
  output logic                    burst_req,
  input  logic                    burst_ack,
  output logic [C_ADDR_WIDTH-1:0] burst_addr,
  output logic [C_DATA_WIDTH-1:0] wr_data,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int c_beat_w  = clogb2(C_BURST_LEN - 1);
  localparam int c_frame_w = clogb2(C_FRAME_WORDS);

  localparam logic [C_CNT_WIDTH-1:0]  c_thresh      = C_CNT_WIDTH'(C_BURST_LEN);
  localparam logic [c_beat_w-1:0]     c_last_beat   = c_beat_w'(C_BURST_LEN - 1);
  localparam logic [C_ADDR_WIDTH-1:0] c_base        = C_ADDR_WIDTH'(C_BASE_ADDR);
  localparam logic [C_ADDR_WIDTH-1:0] c_addr_inc    = C_ADDR_WIDTH'(C_BURST_LEN);
  localparam logic [c_frame_w-1:0]    c_frame_inc   = c_frame_w'(C_BURST_LEN);
  localparam logic [c_frame_w-1:0]    c_frame_words = c_frame_w'(C_FRAME_WORDS);

  state_t                    r_state;
  logic                      r_burst_req;
  logic [C_ADDR_WIDTH-1:0]   r_addr;
  logic [c_beat_w-1:0]       r_beat;
  logic [c_frame_w-1:0]      r_frame_cnt;
  logic                      r_pending;
  logic                      r_frame_done;

  logic                      w_wr_valid;
  logic                      w_accept;
  logic                      w_last_beat;
  logic [c_frame_w-1:0]      w_frame_next;
  logic                      w_frame_wrap;
  logic                      w_restart;

  // Data path is a straight pass-through of the FIFO head; a word moves when
  // the FIFO has one and the controller takes it.
  assign w_wr_valid   = (r_state == S_DATA) & ~fifo_empty;
  assign w_accept     = w_wr_valid & wr_ready;
  assign w_last_beat  = w_accept & (r_beat == c_last_beat);
  assign w_frame_next = r_frame_cnt + c_frame_inc;
  assign w_frame_wrap = (w_frame_next == c_frame_words);
  // A restart requested during the burst, or on its final edge, wins over
  // the normal address increment.
  assign w_restart    = r_pending | frame_start;

  assign wr_data    = fifo_dout;
  assign wr_valid   = w_wr_valid;
  assign fifo_rd_en = w_accept;
  assign burst_req  = r_burst_req;
  assign burst_addr = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

  // Burst FSM with frame address / word tracking and the registered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_burst_req  <= 1'b0;
      r_addr       <= c_base;
      r_beat       <= '0;
      r_frame_cnt  <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_addr      <= c_base;
            r_frame_cnt <= '0;
          end
          if (fifo_count >= c_thresh) begin
            r_state     <= S_REQ;
            r_burst_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (frame_start) r_pending <= 1'b1;
          // Request is held regardless of FIFO level until granted
          if (burst_ack) begin
            r_state     <= S_DATA;
            r_burst_req <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_accept) r_beat <= r_beat + c_beat_w'(1);
          if (w_last_beat) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_pending <= 1'b0;
            if (w_frame_wrap) r_frame_done <= 1'b1;
            if (w_restart || w_frame_wrap) begin
              r_addr      <= c_base;
              r_frame_cnt <= '0;
            end else begin
              r_addr      <= r_addr + c_addr_inc;
              r_frame_cnt <= w_frame_next;
            end
          end else if (frame_start) begin
            r_pending <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_burst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vip_burst_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vip_burst_writer
// Description : Self-checking bench for vip_burst_writer with a FIFO model,
//               a memory-side responder and a scoreboard/phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_burst_writer;

  localparam int DW    = 16;
  localparam int CW    = 5;
  localparam int BL    = 8;
  localparam int AW    = 21;
  localparam int FW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty_r = 1'b1;
  logic          hide = 1'b0;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count = '0;
  logic          fifo_rd_en;
  logic          burst_req;
  logic          burst_ack = 1'b0;
  logic [AW-1:0] burst_addr;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic          busy;
  logic          frame_done;

  assign fifo_empty = fifo_empty_r | hide;

  vip_burst_writer #(
    .C_DATA_WIDTH (DW),
    .C_CNT_WIDTH  (CW),
    .C_BURST_LEN  (BL),
    .C_ADDR_WIDTH (AW),
    .C_BASE_ADDR  (0),
    .C_FRAME_WORDS(FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_rd_en (fifo_rd_en),
    .burst_req  (burst_req),
    .burst_ack  (burst_ack),
    .burst_addr (burst_addr),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model (show-ahead) ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (push_en) fifo_q.push_back(push_data);
    fifo_count   <= CW'(fifo_q.size());
    fifo_empty_r <= (fifo_q.size() == 0);
    fifo_dout    <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // ---------------- memory-side drivers ----------------
  int ready_mode = 0;
  int hide_mode  = 0;
  int ack_delay  = 3;
  int rand_ack   = 0;
  int ack_wait   = 0;

  initial begin
    forever begin
      @(negedge clk);
      burst_ack = 1'b0;
      if (burst_req) begin
        if (ack_wait >= ack_delay) begin
          burst_ack = 1'b1;
          ack_wait  = 0;
          if (rand_ack != 0) ack_delay = $urandom_range(0, 3);
        end else begin
          ack_wait++;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ~wr_ready;
        default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
      hide = (hide_mode != 0) && ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- monitor / reference model ----------------
  // Phase: 0 idle, 1 waiting for grant, 2 streaming. Word position within the
  // frame gives the expected burst address directly (base address is 0).
  int  m_phase = 0;
  int  m_beat = 0;
  int  m_words = 0;
  int  m_pending = 0;
  int  m_done = 0;
  int  bursts_done = 0;
  int  n_frame_done = 0;
  bit  mon_en = 1'b0;
  bit  e_valid;
  bit  e_acc;
  logic [DW-1:0] ed;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        e_valid = (m_phase == 2) && !fifo_empty;
        e_acc   = e_valid && wr_ready;
        check("burst_req", 32'(burst_req), 32'(m_phase == 1));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("wr_valid", 32'(wr_valid), 32'(e_valid));
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(e_acc));
        check("burst_addr", 32'(burst_addr), 32'(m_words));
        check("frame_done", 32'(frame_done), 32'(m_done));
        if (frame_done) n_frame_done++;
        if (e_acc) begin
          if (exp_q.size() == 0) begin
            check("wr_data_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
          end else begin
            ed = exp_q.pop_front();
            check("wr_data", 32'(wr_data), 32'(ed));
          end
        end
        if (rst) begin
          m_phase = 0; m_beat = 0; m_words = 0; m_pending = 0; m_done = 0;
        end else begin
          m_done = 0;
          if (frame_start) begin
            if (m_phase == 0) m_words = 0;
            else m_pending = 1;
          end
          case (m_phase)
            0: if (int'(fifo_count) >= BL) m_phase = 1;
            1: if (burst_ack) m_phase = 2;
            default: begin
              if (e_acc) begin
                m_beat++;
                if (m_beat == BL) begin
                  m_beat  = 0;
                  m_phase = 0;
                  bursts_done++;
                  m_words = m_words + BL;
                  if (m_words == FW) begin
                    m_words = 0;
                    m_done  = 1;
                  end
                  if (m_pending != 0) m_words = 0;
                  m_pending = 0;
                end
              end
            end
          endcase
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input logic [DW-1:0] d, input bit fs);
    int guard;
    guard = 0;
    while (fifo_q.size() >= DEPTH && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("push_timeout", 32'(guard), 32'(0));
    push_en = 1'b1;
    push_data = d;
    frame_start = fs;
    exp_q.push_back(d);
    @(negedge clk);
    push_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_bursts(input int n);
    int g;
    g = 0;
    while (bursts_done < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("burst_count_timeout", 32'(bursts_done >= n), 32'(1));
  endtask

  task automatic wait_beat(input int b);
    int g;
    g = 0;
    while (!(m_phase == 2 && m_beat == b) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("beat_wait_timeout", 32'(g < 1000), 32'(1));
  endtask

  int target = 0;
  int fd0;
  int g;

  initial begin
    // Reset; monitor starts comparing once reset has been sampled.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: basic burst, ack three cycles after request
    for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b0);
    target += 1;
    wait_bursts(target);
    repeat (2) @(negedge clk);
    check("t1_fifo_count", 32'(fifo_count), 32'(0));
    check("t1_next_addr", 32'(burst_addr), 32'(8));

    // 2: backpressure and FIFO underflow windows, slow refill
    ready_mode = 1;
    hide_mode  = 1;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) begin
      push_word(DW'($urandom), 1'b0);
      repeat (2) @(negedge clk);
    end
    target += 2;
    wait_bursts(target);
    hide_mode  = 0;
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // 3: frame wrap after 32 words
    pulse_frame_start();
    fd0 = n_frame_done;
    for (int i = 0; i < FW; i++) push_word(DW'($urandom), 1'b0);
    target += 4;
    wait_bursts(target);
    repeat (3) @(negedge clk);
    check("t3_frame_done_pulses", 32'(n_frame_done - fd0), 32'(1));
    check("t3_addr_wrapped", 32'(burst_addr), 32'(0));

    // 4: frame_start at beat 3 of the burst at address 16
    for (int i = 0; i < 16; i++) push_word(DW'($urandom), 1'b0);
    target += 2;
    wait_bursts(target);
    fd0 = n_frame_done;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0);
    wait_beat(3);
    check("t4_addr_in_flight", 32'(burst_addr), 32'(16));
    pulse_frame_start();
    target += 1;
    wait_bursts(target);
    repeat (2) @(negedge clk);
    check("t4_addr_restart", 32'(burst_addr), 32'(0));
    check("t4_no_frame_done", 32'(n_frame_done - fd0), 32'(0));
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0);
    target += 1;
    wait_bursts(target);

    // 5: reset at beat 5
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0);
    wait_beat(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("t5_addr", 32'(burst_addr), 32'(0));
    check("t5_rd_en", 32'(fifo_rd_en), 32'(0));
    check("t5_req", 32'(burst_req), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    @(negedge clk);
    for (int i = 0; i < 8; i++) push_word(DW'($urandom), 1'b0);
    target += 1;
    wait_bursts(target);
    repeat (2) @(negedge clk);

    // 6: seven words held below threshold
    while (fifo_q.size() < 7) push_word(DW'($urandom), 1'b0);
    repeat (40) @(negedge clk);
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_req", 32'(burst_req), 32'(0));
    push_word(DW'($urandom), 1'b0);
    target += 1;
    wait_bursts(target);

    // Randomized traffic: random ready, grant delay, FIFO gaps, restarts
    ready_mode = 2;
    hide_mode  = 1;
    rand_ack   = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 12)); i++)
        push_word(DW'($urandom), ($urandom_range(0, 19) == 0));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    g = 0;
    while (!(m_phase == 0 && fifo_q.size() < BL) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", 32'(g < 3000), 32'(1));
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
